// File: rtl/hwag_wheel_emulator_if.sv
// rtl/hwag_wheel_emulator_if.sv - control inputs and wheel outputs of the crank/cam emulator
interface hwag_wheel_emulator_if #(
    parameter int PERIOD_W = 24
);
    logic                ena;
    logic [PERIOD_W-1:0] period;
    logic                cap_out;
    logic                cam_out;
    logic [7:0]          tooth_num;
    logic                rev_parity;
    logic                slot_strobe;

    modport master (
        output ena, period,
        input  cap_out, cam_out, tooth_num, rev_parity, slot_strobe
    );

    modport slave (
        input  ena, period,
        output cap_out, cam_out, tooth_num, rev_parity, slot_strobe
    );
endinterface

// File: rtl/hwag_wheel_emulator.sv
// rtl/hwag_wheel_emulator.sv - 60-2 crank and 4-stroke cam signal generator with registered outputs
module hwag_wheel_emulator #(
    parameter int PERIOD_W  = 24,
    parameter int TOOTH_CNT = 60,
    parameter int GAP_TEETH = 2,
    parameter int CAM_START = 10,
    parameter int CAM_LEN   = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    hwag_wheel_emulator_if.slave bus
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(4);
    localparam logic [7:0]          LAST_SLOT = 8'(TOOTH_CNT - 1);
    localparam logic [7:0]          FIRST_GAP = 8'(TOOTH_CNT - GAP_TEETH);
    localparam logic [9:0]          CAM_LO    = 10'(CAM_START);
    localparam logic [9:0]          CAM_HI    = 10'(CAM_START + CAM_LEN);
    localparam logic [9:0]          TWO_REV   = 10'(2 * TOOTH_CNT);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] tick_q, tick_d;
    logic [PERIOD_W-1:0] p_q, p_d;
    logic [7:0]          slot_q, slot_d;
    logic                par_q, par_d;
    logic                cap_q, cap_d;
    logic                cam_q, cam_d;
    logic [7:0]          tooth_q, tooth_d;
    logic                rpar_q, rpar_d;
    logic                strb_q, strb_d;

    // Position within the two-revolution cam cycle; the window may wrap past its end.
    logic [9:0] cam_pos;
    logic       cam_win;
    assign cam_pos = {2'b00, slot_q} + (par_q ? 10'(TOOTH_CNT) : 10'd0);
    assign cam_win = ((cam_pos >= CAM_LO) && (cam_pos < CAM_HI)) || ((cam_pos + TWO_REV) < CAM_HI);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        p_d     = p_q;
        slot_d  = slot_q;
        par_d   = par_q;
        cap_d   = cap_q;
        cam_d   = cam_q;
        tooth_d = tooth_q;
        rpar_d  = rpar_q;
        strb_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cap_d   = 1'b0;
                cam_d   = 1'b0;
                tooth_d = 8'd0;
                rpar_d  = 1'b0;
                if (bus.ena && (bus.period >= MIN_P)) begin
                    state_d = S_RUN;
                    tick_d  = '0;
                    slot_d  = 8'd0;
                    par_d   = 1'b0;
                    p_d     = bus.period;
                end
            end
            S_RUN: begin
                if (bus.ena) begin
                    cap_d   = (tick_q < (p_q >> 1)) && (slot_q < FIRST_GAP);
                    cam_d   = cam_win;
                    tooth_d = slot_q;
                    rpar_d  = par_q;
                    strb_d  = (tick_q == '0);
                    if (tick_q == (p_q - PERIOD_W'(1))) begin
                        tick_d = '0;
                        if (bus.period < MIN_P) begin
                            state_d = S_IDLE;
                            slot_d  = 8'd0;
                            par_d   = 1'b0;
                        end else begin
                            p_d = bus.period;
                            if (slot_q == LAST_SLOT) begin
                                slot_d = 8'd0;
                                par_d  = ~par_q;
                            end else begin
                                slot_d = slot_q + 8'd1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + PERIOD_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            p_q     <= '0;
            slot_q  <= 8'd0;
            par_q   <= 1'b0;
            cap_q   <= 1'b0;
            cam_q   <= 1'b0;
            tooth_q <= 8'd0;
            rpar_q  <= 1'b0;
            strb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            p_q     <= p_d;
            slot_q  <= slot_d;
            par_q   <= par_d;
            cap_q   <= cap_d;
            cam_q   <= cam_d;
            tooth_q <= tooth_d;
            rpar_q  <= rpar_d;
            strb_q  <= strb_d;
        end
    end

    assign bus.cap_out     = cap_q;
    assign bus.cam_out     = cam_q;
    assign bus.tooth_num   = tooth_q;
    assign bus.rev_parity  = rpar_q;
    assign bus.slot_strobe = strb_q;
endmodule

// File: tb/tb_hwag_wheel_emulator.sv
// tb/tb_hwag_wheel_emulator.sv - scoreboard bench for the wheel emulator
module tb_hwag_wheel_emulator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hwag_wheel_emulator_if #(.PERIOD_W(24)) bus();

    hwag_wheel_emulator #(
        .PERIOD_W(24), .TOOTH_CNT(60), .GAP_TEETH(2), .CAM_START(10), .CAM_LEN(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int tooth;
        bit par;
        bit cam;
        int hi;
        int len;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   meas = 1'b0;
    int   hi_c = 0;
    int   len_c = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit cam_rule(input int t, input bit p);
        return (p == 1'b0) && (t >= 10) && (t < 30);
    endfunction

    task automatic push(input int t, input bit p, input int hi, input int len);
        exp_t e;
        e.tooth = t; e.par = p; e.cam = cam_rule(t, p); e.hi = hi; e.len = len;
        q.push_back(e);
    endtask

    task automatic push_rev(input bit p, input int per);
        for (int t = 0; t < 60; t++) push(t, p, (t < 58) ? per / 2 : 0, per);
    endtask

    task automatic wait_slot(input int t, input bit p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.slot_strobe && bus.tooth_num == 8'(t) && bus.rev_parity == p) && n < 3000);
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL wait_slot timeout: slot %0d parity %0d not reached", t, p);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cap"}, bus.cap_out, 0);
        chk({tag, "_cam"}, bus.cam_out, 0);
        chk({tag, "_tooth"}, bus.tooth_num, 0);
        chk({tag, "_par"}, bus.rev_parity, 0);
        chk({tag, "_strobe"}, bus.slot_strobe, 0);
    endtask

    // Monitor: each strobe closes the previous slot's high/length measurement and opens the next.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                meas = 1'b0;
            end else if (bus.slot_strobe) begin
                if (meas) begin
                    chk($sformatf("slot%0d_hi", cur.tooth), hi_c, cur.hi);
                    chk($sformatf("slot%0d_len", cur.tooth), len_c, cur.len);
                end
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: tooth %0d with no slot expected", bus.tooth_num);
                    meas = 1'b0;
                end else begin
                    cur = q.pop_front();
                    chk("strobe_tooth", bus.tooth_num, cur.tooth);
                    chk($sformatf("slot%0d_parity", cur.tooth), bus.rev_parity, cur.par);
                    chk($sformatf("slot%0d_cam", cur.tooth), bus.cam_out, cur.cam);
                    meas  = 1'b1;
                    hi_c  = bus.cap_out ? 1 : 0;
                    len_c = 1;
                end
            end else if (meas) begin
                len_c++;
                if (bus.cap_out) hi_c++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit seen;
        bus.ena    = 1'b1;
        bus.period = 24'd8;
        rst        = 1'b1;
        @(negedge clk);
        chk_zero("reset");

        push_rev(1'b0, 8);
        push_rev(1'b1, 8);
        for (int t = 0; t < 6; t++) push(t, 1'b0, 4, 8);
        push(6, 1'b0, 6, 12);
        push(7, 1'b0, 6, 12);
        for (int t = 8; t < 20; t++) push(t, 1'b0, 3, 7);
        push(20, 1'b0, 53, 57);
        push(21, 1'b0, 0, 0);
        rst = 1'b0;

        wait_slot(0, 1'b1);
        wait_slot(5, 1'b0);
        bus.period = 24'd12;
        wait_slot(7, 1'b0);
        bus.period = 24'd7;

        wait_slot(20, 1'b0);
        @(negedge clk);
        bus.ena = 1'b0;
        repeat (25) @(negedge clk);
        chk("freeze_tooth", bus.tooth_num, 20);
        chk("freeze_cap", bus.cap_out, 1);
        chk("freeze_strobe", bus.slot_strobe, 0);
        repeat (25) @(negedge clk);
        bus.ena = 1'b1;

        wait_slot(21, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_rst_cam", bus.cam_out, 1);
        rst = 1'b1;
        bus.period = 24'd3;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;

        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.cap_out || bus.cam_out || bus.slot_strobe || bus.tooth_num != 8'd0 || bus.rev_parity)
                seen = 1'b1;
        end
        chk("idle_p3_quiet", seen, 0);

        for (int t = 0; t < 3; t++) push(t, 1'b0, 4, 8);
        bus.period = 24'd8;
        wait_slot(2, 1'b0);
        repeat (2) @(negedge clk);
        bus.ena = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
